// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT stage frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } ctrl_state_t;

    localparam int FRAME_CNT_W = 16;

    // Frame length in samples for a given stage depth.
    function automatic int frame_len(input int layer);
        return 1 << layer;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Source/sink handshake plus framing outputs of the frame controller.
// Latency: n/a (wiring only).
// Backpressure: src_ready is driven by the controller from sink_ready.
interface fft_frame_ctrl_if #(
    parameter int LAYER = 3
);
    import fft_pkg::*;

    logic                   en;
    logic                   src_valid;
    logic                   src_ready;
    logic                   sink_ready;
    logic                   stb;
    logic [LAYER-1:0]       idx;
    logic                   start;
    logic                   over;
    logic                   buf_sel;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   busy;

    // Controller side.
    modport slave (
        input  en, src_valid, sink_ready,
        output src_ready, stb, idx, start, over, buf_sel, frame_cnt, busy
    );

    // Source/sink/test side.
    modport master (
        output en, src_valid, sink_ready,
        input  src_ready, stb, idx, start, over, buf_sel, frame_cnt, busy
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo counter (up 0..TERM or down TERM..0) with enable, sync load and wrap flag.
// Latency: count updates on the edge after en/load; wrap is combinational.
// Backpressure: none; holds its value while en is low.
module mod_counter #(
    parameter int           W    = 4,
    parameter logic [W-1:0] TERM = '1,
    parameter bit           DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_end;

    assign at_end = DOWN ? (cnt_q == '0) : (cnt_q == TERM);
    assign wrap   = en && at_end;
    assign cnt    = cnt_q;

    // Next count: load wins, then step or wrap back to the start value.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (at_end) begin
                cnt_d = DOWN ? TERM : '0;
            end else begin
                cnt_d = DOWN ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Cuts a sample stream into 2^LAYER frames, strobes index/start/over, gaps frames.
// Latency: accepted sample at edge k -> stb/idx/start/over registered in cycle k+1.
// Backpressure: src_ready follows sink_ready in RUN only; held low in IDLE and GAP.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int LAYER = 3,
    parameter int GAP   = 2
) (
    input  logic clk,
    input  logic rst,
    fft_frame_ctrl_if.slave io
);

    localparam int               N        = frame_len(LAYER);
    localparam logic [LAYER-1:0] IDX_LAST = LAYER'(N - 1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    ctrl_state_t state_q, state_d;

    logic                   stb_q,       stb_d;
    logic [LAYER-1:0]       idx_q,       idx_d;
    logic                   start_q,     start_d;
    logic                   over_q,      over_d;
    logic                   buf_sel_q,   buf_sel_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             fire;
    logic             frame_done;
    logic [LAYER-1:0] idx_cnt;
    logic             gap_en;
    logic             gap_load;
    logic             gap_done;
    logic [3:0]       gap_cnt;
    logic             gap_cnt_unused;

    // Ready never looks at src_valid, so no valid->ready combinational path.
    assign io.src_ready = (state_q == ST_RUN) && io.sink_ready;
    assign fire         = io.src_ready && io.src_valid;

    assign gap_en   = (state_q == ST_GAP);
    assign gap_load = frame_done && (GAP > 0);
    // Only the wrap flag steers the FSM; the count value itself is not needed.
    assign gap_cnt_unused = ^gap_cnt;

    mod_counter #(
        .W    (LAYER),
        .TERM (IDX_LAST),
        .DOWN (1'b0)
    ) u_idx_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (fire),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (idx_cnt),
        .wrap     (frame_done)
    );

    mod_counter #(
        .W    (4),
        .TERM (GAP_LAST),
        .DOWN (1'b1)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (gap_en),
        .load     (gap_load),
        .load_val (GAP_LAST),
        .cnt      (gap_cnt),
        .wrap     (gap_done)
    );

    // Next state and next registered outputs; en only matters at frame boundaries.
    always_comb begin
        state_d     = state_q;
        stb_d       = fire;
        idx_d       = fire ? idx_cnt : idx_q;
        start_d     = fire && (idx_cnt == '0);
        over_d      = frame_done;
        buf_sel_d   = buf_sel_q ^ frame_done;
        frame_cnt_d = frame_done ? (frame_cnt_q + 1'b1) : frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (io.en && io.src_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_done) begin
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = io.en ? ST_RUN : ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = io.en ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing outputs, ping-pong select and completed-frame count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q       <= 1'b0;
            idx_q       <= '0;
            start_q     <= 1'b0;
            over_q      <= 1'b0;
            buf_sel_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            stb_q       <= stb_d;
            idx_q       <= idx_d;
            start_q     <= start_d;
            over_q      <= over_d;
            buf_sel_q   <= buf_sel_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign io.stb       = stb_q;
    assign io.idx       = idx_q;
    assign io.start     = start_q;
    assign io.over      = over_q;
    assign io.buf_sel   = buf_sel_q;
    assign io.frame_cnt = frame_cnt_q;
    assign io.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for one radix-2 FFT stage. It accepts a continuous sample stream from the source (`data_gen` or the previous stage) and cuts it into frames of N = 2^LAYER complex samples. For each accepted sample it issues a registered strobe, the sample index and `start`/`over` framing pulses, which drive the stage's `start2`/`end2` inputs. It also inserts a fixed idle gap between frames, toggles a ping-pong buffer select and counts completed frames.

## Interface
- `LAYER`, default 3: log2 of frame length; N = 2^LAYER; legal range 1..10.
- `GAP`, default 2: idle cycles inserted after each frame; legal range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset; clears all state and outputs.
- `en` in 1: frame enable; sampled only at frame boundaries.
- `src_valid` in 1: source has a sample this cycle.
- `src_ready` out 1: controller accepts the sample this cycle (combinational).
- `sink_ready` in 1: downstream stage can take a sample.
- `stb` out 1: registered; one accepted sample is on the datapath.
- `idx` out LAYER: registered index (0..N-1) of the sample marked by `stb`.
- `start` out 1: registered; `stb` with `idx` == 0.
- `over` out 1: registered; `stb` with `idx` == N-1.
- `buf_sel` out 1: ping-pong select; toggles when a frame completes.
- `frame_cnt` out 16: number of completed frames; wraps 0xFFFF -> 0.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, GAP.
- IDLE -> RUN when `en` && `src_valid`.
  - `src_ready` = 0 in IDLE, so that cycle accepts nothing.
  - Acceptance begins on the next cycle.
- RUN:
  - `src_ready` = `sink_ready`.
  - fire = `src_valid` && `src_ready`.
  - The internal counter `cnt` advances only on fire.
  - On the fire with `cnt` == N-1:
    - `cnt` -> 0, `buf_sel` toggles, `frame_cnt` increments.
    - Next state: GAP if GAP > 0; otherwise RUN if `en`, else IDLE.
- GAP:
  - `src_ready` = 0.
  - A gap counter loads GAP-1 on entry and counts down.
  - At 0: next state RUN if `en`, else IDLE.
- `en` deasserted mid-frame does not truncate the frame. The frame runs to `over`, then the FSM passes through GAP (if any) to IDLE.
- Stalls:
  - `src_valid` = 0 or `sink_ready` = 0 in RUN: no fire; `cnt` holds.
  - `stb`/`start`/`over` are 0 the following cycle.
- N = 2 (LAYER = 1): `start` and `over` alternate on consecutive fires.
- Reset, asynchronous:
  - state = IDLE; `cnt`, gap counter, `idx`, `frame_cnt` = 0.
  - `stb`, `start`, `over`, `buf_sel`, `busy` = 0.
  - A partially sequenced frame is discarded; the next frame starts at `idx` 0.

## Timing
- Latency: fire at edge k -> `stb`/`idx`/`start`/`over` valid in cycle k+1, for exactly one cycle. This matches the stage's one-cycle input register.
- `src_ready` is combinational from `sink_ready` and state. No combinational path from `src_valid` to `src_ready`.
- `buf_sel` and `frame_cnt` update on the same edge that registers `over`.
- Throughput:
  - Back-to-back frames use N + GAP cycles per frame at full rate.
  - With GAP = 0, consecutive frames are seamless: the `over` of frame f and the `start` of frame f+1 appear on adjacent cycles.
- Entry from IDLE costs one cycle before the first fire.

## Structure
- Shared package `fft_pkg`:
  - FSM state enum `ctrl_state_t` (IDLE/RUN/GAP).
  - `FRAME_CNT_W` = 16.
  - Helper constant function for N from LAYER.
- One sub-module, `mod_counter`: parameterised width and terminal value, with enable, synchronous load and a wrap flag. Instantiated twice: the frame index counter and the gap counter.
- Target size: ~150–250 lines of RTL total.

## Test plan
- Reset, then `en` = 1, `src_valid` = `sink_ready` = 1, LAYER = 3, GAP = 2:
  - first `stb` 2 cycles after `src_valid`;
  - `idx` 0..7 on consecutive cycles, `start` at 0, `over` at 7;
  - 2 idle cycles; second frame `start` at cycle 12 (relative to first `start` = cycle 2);
  - `frame_cnt` 1 -> 2; `buf_sel` 0 -> 1 -> 0.
- `sink_ready` low for 3 cycles while `idx` = 4 is next:
  - `src_ready` = 0 during the stall; no `stb`;
  - `idx` resumes at 4; `over` still at the 8th `stb`.
- Drop `en` at `idx` = 2:
  - frame completes through `over` (`idx` 7), `frame_cnt` = 1;
  - after 2 GAP cycles the FSM is in IDLE, `busy` = 0, `src_ready` = 0.
- Assert `rst` for one cycle at `idx` = 5:
  - all outputs 0 immediately, without waiting for a clock edge;
  - after release, the next frame starts at `idx` 0 and `frame_cnt` restarts from 0.
- GAP = 0, LAYER = 1, continuous input:
  - `stb` every cycle; `start`/`over` alternate;
  - `buf_sel` toggles every 2 cycles.
- Force `frame_cnt` = 0xFFFF via 65535 frames (or a backdoor preload): next `over` -> `frame_cnt` = 0x0000.
